// File: rtl/elastic_pipe_register.sv
// Elastic register chain: DEPTH valid/ready stages with bubble collapsing, synchronous flush and occupancy count.
// Latency: DEPTH cycles from input transfer to out_valid; throughput 1 item/cycle.
// Backpressure: in_ready is combinational from out_ready; optional stall counter under ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe_register #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy,
  output logic [15:0]      stall_count
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] w_adv;
  logic             w_in_fire;
  logic [CNT_W-1:0] w_occ;

  // A stage may load when it is empty, or its successor is empty or itself moving on.
  always_comb begin
    w_adv            = '0;
    w_adv[DEPTH-1]   = !r_v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i] = !r_v[i] | (r_v[i+1] ? w_adv[i+1] : 1'b1);
    end
  end

  assign in_ready  = w_adv[0] & !flush;
  assign w_in_fire = in_valid & in_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_v <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) r_v[i] <= r_v[i-1];
      end
      if (w_adv[0]) r_v[0] <= w_in_fire;
    end
  end

  // Data only toggles when a valid item actually lands; contents of empty stages are don't-care.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i] && r_v[i-1]) r_d[i] <= r_d[i-1];
      end
      if (w_in_fire) r_d[0] <= in_data;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + CNT_W'(r_v[i]);
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign occupancy = w_occ;

`ifdef ELASTIC_PIPE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= 16'h0000;
    end else if (flush) begin
      r_stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule
